// File: rtl/wdt_reset_request.sv
// Watchdog reset-request source: watches the MCU heartbeat toggle and issues
// a fixed-width WD_RES pulse to the reset generator when it stops, with an
// early warning, armed status, a saturating fire counter and last-cause record.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_HOLDOFF  | grace period after reset/enable/fire; kicks ignored, no timeout
// ST_ARMED    | watching for kicks; counter expiry fires
// ST_FIRE     | WD_RES high for PULSE_CYC cycles; all requests ignored
// ST_DISABLED | watchdog off; only force_req can fire
module wdt_reset_request #(
   parameter int TIMEOUT_CYC = 1000000,
   parameter int HOLDOFF_CYC = 100000,
   parameter int PULSE_CYC   = 16,
   parameter int WARN_CYC    = 1000
) (
   input  logic       clk,
   input  logic       SYSTEM_RST,
   input  logic       kick,
   input  logic       wd_en,
   input  logic       force_req,
   input  logic       cause_clr,
   output logic       WD_RES,
   output logic       wd_warn,
   output logic       wd_armed,
   output logic [7:0] reset_count,
   output logic [1:0] last_cause
);

   localparam int MAX_TH  = (TIMEOUT_CYC > HOLDOFF_CYC) ? TIMEOUT_CYC : HOLDOFF_CYC;
   localparam int CNT_MAX = (MAX_TH > PULSE_CYC) ? MAX_TH : PULSE_CYC;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] HOLDOFF_LD = CW'(HOLDOFF_CYC - 1);
   localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYC - 1);
   // One extra bit so a threshold above the counter range still compares true.
   localparam logic [CW:0]   WARN_LIM   =
      (CW+1)'((WARN_CYC > (1 << CW)) ? (1 << CW) : WARN_CYC);

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_FORCED  = 2'b10;

   typedef enum logic [1:0] {
      ST_HOLDOFF,
      ST_ARMED,
      ST_FIRE,
      ST_DISABLED
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          kick_s1_q, kick_s1_d;
   logic          kick_s2_q, kick_s2_d;
   logic          kick_s3_q, kick_s3_d;
   logic          wd_res_q, wd_res_d;
   logic          wd_warn_q, wd_warn_d;
   logic          wd_armed_q, wd_armed_d;
   logic [7:0]    reset_count_q, reset_count_d;
   logic [1:0]    last_cause_q, last_cause_d;
   logic [1:0]    fire_cause;
   logic          kick_evt;

   // Heartbeat synchronizer and edge detect: any toggle is one kick event.
   always_comb begin
      kick_s1_d = kick;
      kick_s2_d = kick_s1_q;
      kick_s3_d = kick_s2_q;
      kick_evt  = kick_s2_q ^ kick_s3_q;
   end

   // Next-state, counter reload/decrement and fire cause.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fire_cause = CAUSE_NONE;
      case (state_q)
         ST_HOLDOFF: begin
            if (force_req) begin
               state_d    = ST_FIRE;
               cnt_d      = PULSE_LD;
               fire_cause = CAUSE_FORCED;
            end else if (!wd_en) begin
               state_d = ST_DISABLED;
            end else if (cnt_q == '0) begin
               state_d = ST_ARMED;
               cnt_d   = TIMEOUT_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_ARMED: begin
            if (force_req) begin
               state_d    = ST_FIRE;
               cnt_d      = PULSE_LD;
               fire_cause = CAUSE_FORCED;
            end else if (!wd_en) begin
               state_d = ST_DISABLED;
            end else if (kick_evt) begin
               cnt_d = TIMEOUT_LD;
            end else if (cnt_q == '0) begin
               state_d    = ST_FIRE;
               cnt_d      = PULSE_LD;
               fire_cause = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FIRE: begin
            if (cnt_q == '0) begin
               state_d = wd_en ? ST_HOLDOFF : ST_DISABLED;
               cnt_d   = HOLDOFF_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DISABLED: begin
            if (force_req) begin
               state_d    = ST_FIRE;
               cnt_d      = PULSE_LD;
               fire_cause = CAUSE_FORCED;
            end else if (wd_en) begin
               state_d = ST_HOLDOFF;
               cnt_d   = HOLDOFF_LD;
            end
         end
         default: begin
            state_d = ST_HOLDOFF;
            cnt_d   = HOLDOFF_LD;
         end
      endcase
   end

   // Outputs follow the next state so they are registered and glitch-free.
   // A clear in the same cycle as a fire lands first, then the fire is counted.
   always_comb begin
      wd_res_d      = (state_d == ST_FIRE);
      wd_armed_d    = (state_d == ST_ARMED);
      wd_warn_d     = (state_d == ST_ARMED) && ({1'b0, cnt_d} < WARN_LIM);
      reset_count_d = reset_count_q;
      last_cause_d  = last_cause_q;
      if (cause_clr) begin
         reset_count_d = 8'd0;
         last_cause_d  = CAUSE_NONE;
      end
      if (fire_cause != CAUSE_NONE) begin
         last_cause_d = fire_cause;
         if (reset_count_d != 8'hFF) begin
            reset_count_d = reset_count_d + 8'd1;
         end
      end
   end

   // State, counter, synchronizer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (SYSTEM_RST) begin
         state_q       <= ST_HOLDOFF;
         cnt_q         <= HOLDOFF_LD;
         kick_s1_q     <= 1'b0;
         kick_s2_q     <= 1'b0;
         kick_s3_q     <= 1'b0;
         wd_res_q      <= 1'b0;
         wd_warn_q     <= 1'b0;
         wd_armed_q    <= 1'b0;
         reset_count_q <= 8'd0;
         last_cause_q  <= CAUSE_NONE;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         kick_s1_q     <= kick_s1_d;
         kick_s2_q     <= kick_s2_d;
         kick_s3_q     <= kick_s3_d;
         wd_res_q      <= wd_res_d;
         wd_warn_q     <= wd_warn_d;
         wd_armed_q    <= wd_armed_d;
         reset_count_q <= reset_count_d;
         last_cause_q  <= last_cause_d;
      end
   end

   assign WD_RES      = wd_res_q;
   assign wd_warn     = wd_warn_q;
   assign wd_armed    = wd_armed_q;
   assign reset_count = reset_count_q;
   assign last_cause  = last_cause_q;

endmodule

// File: tb/tb_wdt_reset_request.sv
// Directed bench for wdt_reset_request with short timing parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// cyc counts rising edges since the last reset release.
module tb_wdt_reset_request;

   logic       clk = 1'b0;
   logic       SYSTEM_RST;
   logic       kick;
   logic       wd_en;
   logic       force_req;
   logic       cause_clr;
   logic       WD_RES;
   logic       wd_warn;
   logic       wd_armed;
   logic [7:0] reset_count;
   logic [1:0] last_cause;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit saw_res;
   bit saw_warn;

   wdt_reset_request #(
      .TIMEOUT_CYC(20),
      .HOLDOFF_CYC(8),
      .PULSE_CYC  (4),
      .WARN_CYC   (5)
   ) dut (
      .clk        (clk),
      .SYSTEM_RST (SYSTEM_RST),
      .kick       (kick),
      .wd_en      (wd_en),
      .force_req  (force_req),
      .cause_clr  (cause_clr),
      .WD_RES     (WD_RES),
      .wd_warn    (wd_warn),
      .wd_armed   (wd_armed),
      .reset_count(reset_count),
      .last_cause (last_cause)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
   endtask

   task automatic do_reset(input logic en);
      SYSTEM_RST = 1'b1;
      kick       = 1'b0;
      force_req  = 1'b0;
      cause_clr  = 1'b0;
      wd_en      = en;
      tick();
      tick();
      SYSTEM_RST = 1'b0;
      cyc        = 0;
   endtask

   initial begin
      // Reset values
      do_reset(1'b1);
      chk("rst_wd_res", WD_RES, 0);
      chk("rst_warn", wd_warn, 0);
      chk("rst_armed", wd_armed, 0);
      chk("rst_count", reset_count, 0);
      chk("rst_cause", last_cause, 0);

      // Free-running timeout with no kicks
      run_to(7);  chk("t1_armed_7", wd_armed, 0);
      run_to(8);  chk("t1_armed_8", wd_armed, 1);
      chk("t1_warn_8", wd_warn, 0);
      run_to(22); chk("t1_warn_22", wd_warn, 0);
      run_to(23); chk("t1_warn_23", wd_warn, 1);
      run_to(27); chk("t1_res_27", WD_RES, 0);
      run_to(28); chk("t1_res_28", WD_RES, 1);
      chk("t1_armed_28", wd_armed, 0);
      chk("t1_warn_28", wd_warn, 0);
      chk("t1_count_28", reset_count, 1);
      chk("t1_cause_28", last_cause, 2'b01);
      run_to(31); chk("t1_res_31", WD_RES, 1);
      run_to(32); chk("t1_res_32", WD_RES, 0);
      run_to(40); chk("t1_armed_40", wd_armed, 1);
      run_to(59); chk("t1_res_59", WD_RES, 0);
      run_to(60); chk("t1_res_60", WD_RES, 1);
      chk("t1_count_60", reset_count, 2);

      // Regular kicks keep it armed; holdoff toggles do not extend holdoff
      do_reset(1'b1);
      run_to(2); kick = ~kick;
      run_to(4); kick = ~kick;
      run_to(7); chk("t2_armed_7", wd_armed, 0);
      run_to(8); chk("t2_armed_8", wd_armed, 1);
      saw_res  = 1'b0;
      saw_warn = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (((cyc - 8) % 15) == 0) kick = ~kick;
         tick();
         if (WD_RES)  saw_res  = 1'b1;
         if (wd_warn) saw_warn = 1'b1;
      end
      chk("t2_no_res", saw_res, 0);
      chk("t2_no_warn", saw_warn, 0);
      chk("t2_armed_end", wd_armed, 1);
      chk("t2_count_end", reset_count, 0);

      // Kick event lands exactly when the counter reaches zero
      do_reset(1'b1);
      run_to(25); kick = ~kick;
      run_to(27); chk("t3_warn_27", wd_warn, 1);
      chk("t3_res_27", WD_RES, 0);
      run_to(28); chk("t3_res_28", WD_RES, 0);
      chk("t3_warn_28", wd_warn, 0);
      chk("t3_armed_28", wd_armed, 1);
      run_to(42); chk("t3_warn_42", wd_warn, 0);
      run_to(43); chk("t3_warn_43", wd_warn, 1);
      run_to(47); chk("t3_res_47", WD_RES, 0);
      run_to(48); chk("t3_res_48", WD_RES, 1);
      chk("t3_cause_48", last_cause, 2'b01);

      // Forced fire beats a same-cycle kick; pulse ignores requests and wd_en
      do_reset(1'b1);
      run_to(8); kick = ~kick;
      run_to(10); force_req = 1'b1;
      tick(); chk("t4_res_11", WD_RES, 1);
      chk("t4_cause_11", last_cause, 2'b10);
      chk("t4_count_11", reset_count, 1);
      chk("t4_armed_11", wd_armed, 0);
      force_req = 1'b0;
      tick(); force_req = 1'b1;
      tick(); force_req = 1'b0;
      chk("t4_res_13", WD_RES, 1);
      chk("t4_count_13", reset_count, 1);
      run_to(14); chk("t4_res_14", WD_RES, 1);
      run_to(15); chk("t4_res_15", WD_RES, 0);
      run_to(23); chk("t4_armed_23", wd_armed, 1);
      run_to(25); force_req = 1'b1;
      tick(); force_req = 1'b0; wd_en = 1'b0;
      chk("t4_res_26", WD_RES, 1);
      chk("t4_count_26", reset_count, 2);
      run_to(29); chk("t4_res_29", WD_RES, 1);
      run_to(30); chk("t4_res_30", WD_RES, 0);
      run_to(60); chk("t4_dis_res_60", WD_RES, 0);
      chk("t4_dis_armed_60", wd_armed, 0);
      force_req = 1'b1;
      tick(); force_req = 1'b0;
      chk("t4_dis_force_res", WD_RES, 1);
      chk("t4_dis_force_count", reset_count, 3);
      chk("t4_dis_force_cause", last_cause, 2'b10);
      run_to(65); chk("t4_res_65", WD_RES, 0);
      wd_en = 1'b1;
      run_to(73); chk("t4_armed_73", wd_armed, 0);
      run_to(74); chk("t4_armed_74", wd_armed, 1);

      // Saturation of the fire counter and clear interaction
      do_reset(1'b0);
      for (int i = 1; i <= 260; i++) begin
         force_req = 1'b1;
         tick();
         force_req = 1'b0;
         repeat (4) tick();
         if (i == 100) chk("t5_count_100", reset_count, 100);
         if (i == 254) chk("t5_count_254", reset_count, 254);
         if (i == 255) chk("t5_count_255", reset_count, 255);
      end
      chk("t5_count_260", reset_count, 255);
      chk("t5_cause_260", last_cause, 2'b10);
      force_req = 1'b1;
      cause_clr = 1'b1;
      tick();
      force_req = 1'b0;
      cause_clr = 1'b0;
      chk("t5_clr_fire_count", reset_count, 1);
      chk("t5_clr_fire_cause", last_cause, 2'b10);
      repeat (4) tick();
      cause_clr = 1'b1;
      tick();
      cause_clr = 1'b0;
      chk("t5_clr_count", reset_count, 0);
      chk("t5_clr_cause", last_cause, 2'b00);

      // Reset on the second cycle of a pulse
      wd_en     = 1'b1;
      force_req = 1'b1;
      tick();
      force_req = 1'b0;
      chk("t6_res_fire", WD_RES, 1);
      chk("t6_count_fire", reset_count, 1);
      SYSTEM_RST = 1'b1;
      tick();
      chk("t6_res_rst", WD_RES, 0);
      chk("t6_warn_rst", wd_warn, 0);
      chk("t6_armed_rst", wd_armed, 0);
      chk("t6_count_rst", reset_count, 0);
      chk("t6_cause_rst", last_cause, 0);
      SYSTEM_RST = 1'b0;
      cyc = 0;
      run_to(4); chk("t6_res_4", WD_RES, 0);
      run_to(7); chk("t6_armed_7", wd_armed, 0);
      run_to(8); chk("t6_armed_8", wd_armed, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
